paralelo_serial_tx: RTL and testbench

- Parallel-to-serial transmit stage. It sits directly upstream of the serial-to-parallel/IDL receiver and produces the bit stream that receiver aligns on and decodes.
- Takes 8-bit bytes with a valid flag and shifts them out MSB-first at one bit per clk_32f.
- After reset it sends a fixed burst of COM symbols so the receiver can assert active. From then on it sends data bytes, or the IDL symbol whenever no data is offered.
- Single clock domain. Byte timing comes from an internal divide-by-8 counter, so no clk_4f is needed.

---
 rtl/paralelo_serial_tx_if.sv | 19 +
 rtl/paralelo_serial_tx.sv | 90 +++++++++
 tb/tb_paralelo_serial_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/paralelo_serial_tx_if.sv
// Byte-in / bit-out bundle for the parallel-to-serial transmit stage.
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;
  logic       data_out;
  logic       load_strobe;
  logic [1:0] sym_type;

  modport master (
    output data_in, valid_in,
    input  ready, data_out, load_strobe, sym_type
  );

  modport slave (
    input  data_in, valid_in,
    output ready, data_out, load_strobe, sym_type
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial TX: COM burst after reset, then DATA/IDL bytes MSB-first.
// Optional PARALELO_SERIAL_TX_STATS_EN adds a 16-bit accepted-byte counter.
module paralelo_serial_tx #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter logic [7:0] IDL_SYMBOL = 8'h7C,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic clk_32f,
  input  logic reset,
`ifdef PARALELO_SERIAL_TX_STATS_EN
  paralelo_serial_tx_if.slave bus,
  output logic [15:0] tx_bytes
`else
  paralelo_serial_tx_if.slave bus
`endif
);

  typedef enum logic {
    SYNC,
    RUN
  } state_t;

  localparam logic [1:0] T_COM  = 2'b00;
  localparam logic [1:0] T_IDL  = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [3:0] COM_LAST = 4'(COM_COUNT - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] sreg;
  logic [3:0] com_cnt;
  logic       load_strobe;
  logic [1:0] sym_type;
  logic       load;
  logic       ready;

  assign load  = (bit_cnt == 3'd7);
  assign ready = (state == RUN) && load;

  assign bus.ready       = ready;
  assign bus.data_out    = sreg[7];
  assign bus.load_strobe = load_strobe;
  assign bus.sym_type    = sym_type;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      bit_cnt     <= 3'd7;
      sreg        <= 8'h00;
      com_cnt     <= 4'd0;
      load_strobe <= 1'b0;
      sym_type    <= T_COM;
    end else begin
      bit_cnt     <= bit_cnt + 3'd1;
      load_strobe <= load;
      if (load) begin
        unique case (state)
          SYNC: begin
            sreg     <= COM_SYMBOL;
            sym_type <= T_COM;
            com_cnt  <= com_cnt + 4'd1;
            if (com_cnt == COM_LAST)
              state <= RUN;
          end
          RUN: begin
            if (bus.valid_in) begin
              sreg     <= bus.data_in;
              sym_type <= T_DATA;
            end else begin
              sreg     <= IDL_SYMBOL;
              sym_type <= T_IDL;
            end
          end
        endcase
      end else begin
        sreg <= {sreg[6:0], 1'b0};
      end
    end
  end

`ifdef PARALELO_SERIAL_TX_STATS_EN
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset)
      tx_bytes <= 16'd0;
    else if (ready && bus.valid_in)
      tx_bytes <= tx_bytes + 16'd1;
  end
`endif

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx against a slot-level line model.
module tb_paralelo_serial_tx;

  localparam int COMS = 4;
  localparam int SYNC_CYC = 8 * COMS;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;

  paralelo_serial_tx_if bus ();

`ifdef PARALELO_SERIAL_TX_STATS_EN
  logic [15:0] tx_bytes;
  paralelo_serial_tx dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus.slave),
    .tx_bytes(tx_bytes)
  );
`else
  paralelo_serial_tx dut (
    .clk_32f(clk_32f),
    .reset  (reset),
    .bus    (bus.slave)
  );
`endif

  always #5 clk_32f = ~clk_32f;

  int compared   = 0;
  int mismatched = 0;

  // Line model: k counts edges since reset release; byte slot = k/8.
  int         k = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [1:0] cur_type = 2'b00;
  int         accepts  = 0;
  logic [7:0] sent_q[$];

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s k=%0d got %0h exp %0h", tag, k, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic v, input logic [7:0] d);
    logic exp_rdy;
    bus.valid_in = v;
    bus.data_in  = d;
    #1;
    exp_rdy = (k % 8 == 0) && (k >= SYNC_CYC);
    chk("ready", 16'(bus.ready), 16'(exp_rdy));
    @(posedge clk_32f);
    if (k % 8 == 0) begin
      if (k < SYNC_CYC) begin
        cur_byte = 8'hBC; cur_type = 2'b00;
      end else if (v) begin
        cur_byte = d; cur_type = 2'b10; accepts++;
      end else begin
        cur_byte = 8'h7C; cur_type = 2'b01;
      end
      sent_q.push_back(cur_byte);
    end
    #1;
    chk("data_out", 16'(bus.data_out), 16'(cur_byte[7 - (k % 8)]));
    chk("sym_type", 16'(bus.sym_type), 16'(cur_type));
    chk("load_strobe", 16'(bus.load_strobe), 16'(k % 8 == 0));
`ifdef PARALELO_SERIAL_TX_STATS_EN
    chk("tx_bytes", tx_bytes, 16'(accepts));
`endif
    k++;
    @(negedge clk_32f);
  endtask

  task automatic check_reset_state();
    #1;
    chk("rst_data_out", 16'(bus.data_out), 16'd0);
    chk("rst_sym_type", 16'(bus.sym_type), 16'd0);
    chk("rst_strobe", 16'(bus.load_strobe), 16'd0);
    chk("rst_ready", 16'(bus.ready), 16'd0);
`ifdef PARALELO_SERIAL_TX_STATS_EN
    chk("rst_tx_bytes", tx_bytes, 16'd0);
`endif
  endtask

  task automatic release_reset(input int hold);
    repeat (hold) @(negedge clk_32f);
    check_reset_state();
    reset = 1'b1;
    k = 0; accepts = 0;
    cur_byte = 8'h00; cur_type = 2'b00;
    sent_q.delete();
  endtask

  task automatic align();
    while (k % 8 != 0) step(1'b0, 8'h00);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    @(negedge clk_32f);
    // 1: COM burst then IDL
    release_reset(3);
    repeat (SYNC_CYC + 16) step(1'b0, 8'h00);
    for (int i = 0; i < COMS; i++)
      chk("sync_byte", 16'(sent_q[i]), 16'hBC);
    chk("idl_byte", 16'(sent_q[COMS]), 16'h7C);

    // 2: single A5 then IDL
    align();
    step(1'b1, 8'hA5);
    repeat (15) step(1'b0, 8'h00);
    chk("a5_byte", 16'(sent_q[$ - 1]), 16'hA5);

    // 3: back-to-back 01, FF; non-ready edges ignore data
    step(1'b1, 8'h01);
    repeat (7) step(1'b1, 8'h55);
    step(1'b1, 8'hFF);
    repeat (7) step(1'b0, 8'h00);
    chk("b2b_ff", 16'(sent_q[$]), 16'hFF);

    // 4: valid held through SYNC
    reset = 1'b0;
    release_reset(2);
    repeat (SYNC_CYC + 24) step(1'b1, 8'h3C);
    chk("hold_com", 16'(sent_q[COMS - 1]), 16'hBC);
    chk("hold_3c", 16'(sent_q[COMS]), 16'h3C);

    // 5: reset in the middle of a DATA byte
    align();
    step(1'b1, 8'hFF);
    repeat (4) step(1'b0, 8'h00);
    reset = 1'b0;
    check_reset_state();
    release_reset(2);
    repeat (SYNC_CYC + 8) step(1'b0, 8'h00);

    // 6: randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom % 2), 8'($urandom));

`ifdef PARALELO_SERIAL_TX_STATS_EN
    reset = 1'b0;
    release_reset(1);
    repeat (SYNC_CYC) step(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step((i % 3) == 0, 8'(i + 1));
      repeat (7) step(1'b0, 8'h00);
    end
    chk("stats3", tx_bytes, 16'd3);
    reset = 1'b0;
    check_reset_state();
    reset = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule
